// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - EX-stage operand forwarding, load-use and mult/div stall control
module hazard_ctrl #(
  parameter int MD_LAT = 6,
  parameter int CNT_W  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       ex_ra,
  input  logic [4:0]       ex_rb,
  input  logic             ex_uses_rb,
  input  logic             ex_md_start,
  input  logic             ex_hilo_read,
  input  logic [4:0]       mem_rw,
  input  logic             mem_regwrite,
  input  logic             mem_is_load,
  input  logic [4:0]       wb_rw,
  input  logic             wb_regwrite,
  output logic             stall,
  output logic             bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             md_busy,
  output logic [1:0]       stall_cause,
  output logic [CNT_W-1:0] stall_count
);

  localparam int MD_W = $clog2(MD_LAT + 1);

  typedef enum logic {RUN, LS_HOLD} state_t;

  state_t          state;
  logic [MD_W-1:0] md_cnt;

  logic mem_match_a, mem_match_b, wb_match_a, wb_match_b;
  logic lu, mh, hazard;

  // Register r0 is hardwired zero, so it never matches a producer
  assign mem_match_a = mem_regwrite && (mem_rw == ex_ra) && (ex_ra != 5'd0);
  assign mem_match_b = ex_uses_rb && mem_regwrite && (mem_rw == ex_rb) && (ex_rb != 5'd0);
  assign wb_match_a  = wb_regwrite && (wb_rw == ex_ra) && (ex_ra != 5'd0);
  assign wb_match_b  = ex_uses_rb && wb_regwrite && (wb_rw == ex_rb) && (ex_rb != 5'd0);

  // A second load-use stall for the same consumer is blocked by LS_HOLD
  assign lu      = (mem_match_a || mem_match_b) && mem_is_load && (state == RUN);
  assign md_busy = (md_cnt != '0);
  assign mh      = md_busy && (ex_hilo_read || ex_md_start);
  assign hazard  = lu || mh;

  // Forward selects and stall outputs, all held quiet while in reset
  always_comb begin
    fwd_a       = 2'b00;
    fwd_b       = 2'b00;
    stall       = 1'b0;
    stall_cause = 2'b00;
    if (!reset) begin
      if (mem_match_a)     fwd_a = 2'b01;
      else if (wb_match_a) fwd_a = 2'b10;
      if (mem_match_b)     fwd_b = 2'b01;
      else if (wb_match_b) fwd_b = 2'b10;
      stall       = hazard;
      stall_cause = {mh, lu};
    end
  end

  assign bubble = stall;

  // Load-use guard FSM: one cycle of LS_HOLD after every load-use stall
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     if (lu) state <= LS_HOLD;
        LS_HOLD: state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  // Mult/div occupancy: a start is only accepted when EX is not held
  always_ff @(posedge clock) begin
    if (reset) begin
      md_cnt <= '0;
    end else if (ex_md_start && !stall) begin
      md_cnt <= MD_W'(MD_LAT);
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - MD_W'(1);
    end
  end

  // Saturating count of stalled cycles
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;

  localparam int CNT_W = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic [4:0]       ex_ra, ex_rb, mem_rw, wb_rw;
  logic             ex_uses_rb, ex_md_start, ex_hilo_read;
  logic             mem_regwrite, mem_is_load, wb_regwrite;
  logic             stall, bubble, md_busy;
  logic [1:0]       fwd_a, fwd_b, stall_cause;
  logic [CNT_W-1:0] stall_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int               step;
    logic             stall;
    logic [1:0]       fa;
    logic [1:0]       fb;
    logic             busy;
    logic [1:0]       cause;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   step_no = 0;

  hazard_ctrl #(.MD_LAT(6), .CNT_W(CNT_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .ex_ra        (ex_ra),
    .ex_rb        (ex_rb),
    .ex_uses_rb   (ex_uses_rb),
    .ex_md_start  (ex_md_start),
    .ex_hilo_read (ex_hilo_read),
    .mem_rw       (mem_rw),
    .mem_regwrite (mem_regwrite),
    .mem_is_load  (mem_is_load),
    .wb_rw        (wb_rw),
    .wb_regwrite  (wb_regwrite),
    .stall        (stall),
    .bubble       (bubble),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .md_busy      (md_busy),
    .stall_cause  (stall_cause),
    .stall_count  (stall_count)
  );

  always #5 clock = ~clock;

  task automatic drive(input logic rst, input logic [4:0] ra, input logic [4:0] rb,
                       input logic urb, input logic mds, input logic hilo,
                       input logic [4:0] mrw, input logic mrg, input logic mld,
                       input logic [4:0] wrw, input logic wrg);
    reset        = rst;
    ex_ra        = ra;
    ex_rb        = rb;
    ex_uses_rb   = urb;
    ex_md_start  = mds;
    ex_hilo_read = hilo;
    mem_rw       = mrw;
    mem_regwrite = mrg;
    mem_is_load  = mld;
    wb_rw        = wrw;
    wb_regwrite  = wrg;
  endtask

  // Push the expectation for the currently driven inputs, then compare mid-cycle
  task automatic step(input logic st, input logic [1:0] fa, input logic [1:0] fb,
                      input logic busy, input logic [1:0] cause, input logic [CNT_W-1:0] cnt);
    exp_t e;
    sb.push_back('{step_no, st, fa, fb, busy, cause, cnt});
    @(negedge clock);
    e = sb.pop_front();
    total++;
    assert (stall === e.stall) else begin bad++; $error("FAIL step%0d stall got=%b exp=%b", e.step, stall, e.stall); end
    total++;
    assert (bubble === e.stall) else begin bad++; $error("FAIL step%0d bubble got=%b exp=%b", e.step, bubble, e.stall); end
    total++;
    assert (fwd_a === e.fa) else begin bad++; $error("FAIL step%0d fwd_a got=%b exp=%b", e.step, fwd_a, e.fa); end
    total++;
    assert (fwd_b === e.fb) else begin bad++; $error("FAIL step%0d fwd_b got=%b exp=%b", e.step, fwd_b, e.fb); end
    total++;
    assert (md_busy === e.busy) else begin bad++; $error("FAIL step%0d md_busy got=%b exp=%b", e.step, md_busy, e.busy); end
    total++;
    assert (stall_cause === e.cause) else begin bad++; $error("FAIL step%0d stall_cause got=%b exp=%b", e.step, stall_cause, e.cause); end
    total++;
    assert (stall_count === e.cnt) else begin bad++; $error("FAIL step%0d stall_count got=%0d exp=%0d", e.step, stall_count, e.cnt); end
    @(posedge clock);
    #1;
    step_no++;
  endtask

  initial begin
    // Two reset cycles; outputs forced low even with a live load-use pattern
    drive(1, 5'd5, 0, 0, 0, 0, 5'd5, 1, 1, 0, 0);
    @(posedge clock);
    #1;
    step(0, 2'b00, 2'b00, 0, 2'b00, 0);

    // MEM wins over WB
    drive(0, 5'd5, 0, 0, 0, 0, 5'd5, 1, 0, 5'd5, 1);
    step(0, 2'b01, 2'b00, 0, 2'b00, 0);
    // WB only
    drive(0, 5'd5, 0, 0, 0, 0, 5'd6, 1, 0, 5'd5, 1);
    step(0, 2'b10, 2'b00, 0, 2'b00, 0);
    // r0 never forwards; rb ignored when unused
    drive(0, 5'd0, 5'd7, 0, 0, 0, 5'd0, 1, 0, 5'd7, 1);
    step(0, 2'b00, 2'b00, 0, 2'b00, 0);
    // rb used now
    drive(0, 5'd0, 5'd7, 1, 0, 0, 5'd0, 1, 0, 5'd7, 1);
    step(0, 2'b00, 2'b10, 0, 2'b00, 0);
    // MEM without regwrite does not match
    drive(0, 5'd3, 0, 0, 0, 0, 5'd3, 0, 0, 5'd3, 1);
    step(0, 2'b10, 2'b00, 0, 2'b00, 0);

    // Load-use on rb, then load moves to WB with a NOP in MEM
    drive(0, 5'd1, 5'd9, 1, 0, 0, 5'd9, 1, 1, 0, 0);
    step(1, 2'b00, 2'b01, 0, 2'b01, 0);
    drive(0, 5'd1, 5'd9, 1, 0, 0, 5'd0, 0, 0, 5'd9, 1);
    step(0, 2'b00, 2'b10, 0, 2'b00, 1);
    // Load held in MEM: stall once, LS_HOLD guard clears it
    drive(0, 5'd9, 0, 0, 0, 0, 5'd9, 1, 1, 0, 0);
    step(1, 2'b01, 2'b00, 0, 2'b01, 1);
    step(0, 2'b01, 2'b00, 0, 2'b00, 2);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 2'b00, 2'b00, 0, 2'b00, 2);

    // mult accepted, then mflo stalls for MD_LAT cycles
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 2'b00, 2'b00, 0, 2'b00, 2);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 2'b00, 2'b00, 1, 2'b10, CNT_W'(2 + i));
    step(0, 2'b00, 2'b00, 0, 2'b00, 8);

    // Simultaneous load-use and md-busy
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 2'b00, 2'b00, 0, 2'b00, 8);
    drive(0, 5'd4, 0, 0, 0, 1, 5'd4, 1, 1, 0, 0);
    step(1, 2'b01, 2'b00, 1, 2'b11, 8);
    step(1, 2'b01, 2'b00, 1, 2'b10, 9);
    // Start while busy stalls and must not reload the counter
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step(1, 2'b00, 2'b00, 1, 2'b10, 10);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 2'b00, 2'b00, 1, 2'b00, 11);
    step(0, 2'b00, 2'b00, 1, 2'b00, 11);
    step(0, 2'b00, 2'b00, 1, 2'b00, 11);
    step(0, 2'b00, 2'b00, 0, 2'b00, 11);

    // Drive the counter into saturation
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 2'b00, 2'b00, 0, 2'b00, 11);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    step(1, 2'b00, 2'b00, 1, 2'b10, 11);
    step(1, 2'b00, 2'b00, 1, 2'b10, 12);
    step(1, 2'b00, 2'b00, 1, 2'b10, 13);
    step(1, 2'b00, 2'b00, 1, 2'b10, 14);
    step(1, 2'b00, 2'b00, 1, 2'b10, 15);
    step(1, 2'b00, 2'b00, 1, 2'b10, 15);
    step(0, 2'b00, 2'b00, 0, 2'b00, 15);

    // Reset during md busy
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 2'b00, 2'b00, 0, 2'b00, 15);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    step(1, 2'b00, 2'b00, 1, 2'b10, 15);
    drive(1, 5'd5, 5'd5, 1, 0, 1, 5'd5, 1, 0, 0, 0);
    step(0, 2'b00, 2'b00, 1, 2'b00, 15);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 2'b00, 2'b00, 0, 2'b00, 0);

    // Reset during LS_HOLD returns the FSM to RUN
    drive(0, 5'd2, 0, 0, 0, 0, 5'd2, 1, 1, 0, 0);
    step(1, 2'b01, 2'b00, 0, 2'b01, 0);
    reset = 1'b1;
    step(0, 2'b00, 2'b00, 0, 2'b00, 1);
    reset = 1'b0;
    step(1, 2'b01, 2'b00, 0, 2'b01, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage integer pipeline. It evaluates the instruction in EX against producers in MEM and WB and drives the EX operand-forwarding selects. It stalls IF/ID/EX for one cycle on a load-use hazard and stalls while the multi-cycle multiply/divide unit is busy. It replaces ad-hoc forwarding/stall logic in the top level and sits beside the decode/exec stage registers.

## Interface
- MD_LAT, 6, multiply/divide busy cycles after an accepted start (≥1)
- CNT_W, 16, width of stall performance counter

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- ex_ra  in  5  EX source register A
- ex_rb  in  5  EX source register B
- ex_uses_rb  in  1  EX instruction reads rb (R-type / opcode 1)
- ex_md_start  in  1  EX instruction is mult/div
- ex_hilo_read  in  1  EX instruction reads HI/LO (mfhi/mflo)
- mem_rw  in  5  MEM destination register
- mem_regwrite  in  1  MEM instruction writes register file
- mem_is_load  in  1  MEM instruction is a load (lb/lh/lw/lbu/lhu/lf)
- wb_rw  in  5  WB destination register
- wb_regwrite  in  1  WB instruction writes register file
- stall  out  1  hold PC, IF/ID and ID/EX registers
- bubble  out  1  load NOP into EX/MEM register (equals stall)
- fwd_a  out  2  00 regfile, 01 MEM aluout, 10 WB busW
- fwd_b  out  2  same encoding for operand B
- md_busy  out  1  multiply/divide unit occupied
- stall_cause  out  2  [0] load-use, [1] md-busy
- stall_count  out  CNT_W  saturating count of stall cycles

## Operation
- Match rules: a producer matches source s iff regwrite=1, rw==s, s!=0. rb is only considered when ex_uses_rb=1. Otherwise fwd_b=00.
- Forward priority: MEM match → 01, else WB match → 10, else 00. Evaluated independently for A and B.
- Load-use hazard (lu): MEM matches ra or (used) rb AND mem_is_load=1 AND state==RUN.
- MD hazard (mh): md_busy AND (ex_hilo_read OR ex_md_start).
- stall = bubble = lu | mh (combinational, same cycle).
- stall_cause = {mh, lu}.
- FSM, 2 states:
  - RUN: lu=1 → LS_HOLD.
  - LS_HOLD: lu is forced 0 (guarantees at most one load stall per consumer). Returns to RUN next cycle unconditionally.
- While stalled, fwd_a/fwd_b still reflect the match rules. Downstream ignores them because EX is held.
- MD counter md_cnt (width ⌈log2(MD_LAT+1)⌉):
  - Accepted start (ex_md_start & ~stall) loads MD_LAT.
  - Otherwise decrements when non-zero.
  - md_busy = (md_cnt != 0).
- stall_count increments on each stall=1 cycle and saturates at all-ones.
- Reset: state=RUN, md_cnt=0, stall_count=0. While reset=1, stall, bubble, fwd_a, fwd_b and stall_cause are forced 0.

## Timing
- Forward selects and stall are combinational from inputs and registered state. There is no added latency.
- Load-use sequence:
  - Cycle t: consumer in EX, load in MEM → stall=1, bubble=1, state→LS_HOLD.
  - Cycle t+1: load in WB, NOP in MEM → stall=0 and fwd=10.
- Start accepted at cycle t → md_busy=1 for cycles t+1..t+MD_LAT, 0 at t+MD_LAT+1.
- mfhi in EX during busy stalls until the first cycle md_busy=0.
- Simultaneous lu and mh: stall=1 and stall_cause=11. FSM still enters LS_HOLD. Stall continues while mh persists.
- ex_md_start while busy does not reload the counter; it stalls.
- Reset asserted mid-stall: next cycle state=RUN, md_busy=0, stall=0. A counter at terminal value stays saturated until reset.

## Test plan
- EX add ra=5, MEM add rw=5 regwrite=1, WB rw=5 → fwd_a=01 (MEM wins), stall=0.
- EX ra=0, MEM rw=0 regwrite=1 → fwd_a=00. EX rb=7 ex_uses_rb=0, WB rw=7 → fwd_b=00.
- MEM lw rw=9, EX rb=9 ex_uses_rb=1 → stall=1, bubble=1, stall_cause=01 for exactly 1 cycle. Next cycle with WB rw=9 → fwd_b=10, stall=0.
- MEM lw rw=9 held constant (no bubble), EX ra=9 → stall=1 then 0 (LS_HOLD guard). stall_count=1.
- mult accepted, then mflo in EX with MD_LAT=6 → stall=1, stall_cause=10 until md_busy falls. Total 6 stall cycles counted minus issue gap.
- Assert reset during md_busy=1 → next cycle md_busy=0, stall=0, stall_count=0, fwd_a=fwd_b=00.
